gmii_tx_framer: RTL and testbench

//  Turns an upstream byte stream (ARP/UDP packet builder: dest MAC..payload) into a legal GMII frame.

---
 rtl/eth_pkg.sv | 28 ++
 rtl/gmii_tx_framer_if.sv | 17 +
 rtl/crc32_d8.sv | 23 ++
 rtl/gmii_tx_framer.sv | 158 +++++++++++++++
 tb/tb_gmii_tx_framer.sv | 402 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/eth_pkg.sv
// Shared Ethernet constants and types for the GMII transmit path.
//   ETH_PREAMBLE / ETH_SFD : preamble and start-of-frame-delimiter bytes
//   CRC32_INIT / POLY_R    : CRC-32 seed and reflected polynomial
//   cnt_t                  : 11-bit saturating frame/phase counter type
//   tx_state_t             : framer FSM state encoding
package eth_pkg;

    localparam logic [7:0]  ETH_PREAMBLE = 8'h55;
    localparam logic [7:0]  ETH_SFD      = 8'hD5;
    localparam logic [31:0] CRC32_INIT   = 32'hFFFF_FFFF;
    localparam logic [31:0] CRC32_POLY_R = 32'hEDB8_8320;

    localparam int CNT_W = 11;
    typedef logic [CNT_W-1:0] cnt_t;
    localparam cnt_t CNT_MAX = '1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PRE,
        ST_SFD,
        ST_DATA,
        ST_PAD,
        ST_FCS,
        ST_IFG,
        ST_DROP
    } tx_state_t;

endpackage

// File: rtl/gmii_tx_framer_if.sv
// Byte-stream handshake between the packet builder and the GMII framer.
//   s_data  : frame byte, destination MAC first
//   s_valid : s_data valid
//   s_last  : last byte of the frame
//   s_ready : byte accepted when s_valid && s_ready
// master = packet source, slave = framer.
interface gmii_tx_framer_if;

    logic [7:0] s_data;
    logic       s_valid;
    logic       s_last;
    logic       s_ready;

    modport master (output s_data, output s_valid, output s_last, input s_ready);
    modport slave  (input s_data, input s_valid, input s_last, output s_ready);

endinterface

// File: rtl/crc32_d8.sv
// Combinational CRC-32 next-state function, one byte per clock.
// Reflected (LSB-first) form; the caller owns the CRC register.
//   crc_in  : current CRC register
//   data    : byte to absorb, bit 0 first
//   crc_out : CRC register after absorbing data
module crc32_d8
    import eth_pkg::*;
(
    input  logic [31:0] crc_in,
    input  logic [7:0]  data,
    output logic [31:0] crc_out
);

    // NOTE: crc_out is given a value before the loop on every evaluation, so
    // no path leaves it unassigned and no latch is inferred.
    always_comb begin
        crc_out = crc_in;
        for (int i = 0; i < 8; i++) begin
            crc_out = (crc_out >> 1) ^ ((crc_out[0] ^ data[i]) ? CRC32_POLY_R : 32'h0);
        end
    end

endmodule

// File: rtl/gmii_tx_framer.sv
// GMII transmit framer: wraps an upstream byte stream with preamble/SFD,
// zero-pads short frames, appends the CRC-32 FCS and enforces the IFG.
//   gmii_tx_clk : 125 MHz GMII transmit clock
//   rst         : synchronous, active-high reset
//   up          : upstream byte stream (slave side)
//   gmii_tx_dv  : GMII transmit enable (registered)
//   gmii_txd    : GMII transmit data (registered)
//   tx_busy     : high whenever the FSM is not idle
//   tx_done     : one-cycle pulse on the first idle cycle after the FCS
//   underrun    : one-cycle pulse when the source stalls mid-frame
module gmii_tx_framer
    import eth_pkg::*;
#(
    parameter int PREAMBLE_LEN = 7,
    parameter int MIN_FRAME    = 60,
    parameter int IFG_BYTES    = 12
) (
    input  logic            gmii_tx_clk,
    input  logic            rst,
    gmii_tx_framer_if.slave up,
    output logic            gmii_tx_dv,
    output logic [7:0]      gmii_txd,
    output logic            tx_busy,
    output logic            tx_done,
    output logic            underrun
);

    localparam cnt_t PRE_CNT = cnt_t'(PREAMBLE_LEN);
    localparam cnt_t MIN_CNT = cnt_t'(MIN_FRAME);
    localparam cnt_t IFG_CNT = cnt_t'(IFG_BYTES);

    tx_state_t   state;
    cnt_t        cnt;        // preamble / byte / FCS / IFG counter, reused per phase
    cnt_t        cnt_inc;
    logic [31:0] crc;
    logic [31:0] crc_next;
    logic [31:0] fcs_word;
    logic [7:0]  crc_byte;
    logic [7:0]  fcs_byte;

    // The state names what gets launched on the next edge, so the byte
    // accepted in DATA leaves the output register one cycle later.
    assign up.s_ready = (state == ST_DATA) || (state == ST_DROP);
    assign tx_busy    = (state != ST_IDLE);

    // Saturating increment: the byte count only ever compares against MIN_FRAME.
    assign cnt_inc  = (cnt == CNT_MAX) ? cnt : cnt + cnt_t'(1);

    assign crc_byte = (state == ST_PAD) ? 8'h00 : up.s_data;
    assign fcs_word = ~crc;
    assign fcs_byte = fcs_word[{cnt[1:0], 3'b000} +: 8];

    crc32_d8 u_crc (
        .crc_in  (crc),
        .data    (crc_byte),
        .crc_out (crc_next)
    );

    // NOTE: every register here uses <= so all branches see pre-edge values
    // and later assignments in a branch cleanly override earlier defaults.
    always_ff @(posedge gmii_tx_clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            crc        <= CRC32_INIT;
            gmii_tx_dv <= 1'b0;
            gmii_txd   <= 8'h00;
            tx_done    <= 1'b0;
            underrun   <= 1'b0;
        end else begin
            tx_done  <= 1'b0;
            underrun <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    gmii_tx_dv <= 1'b0;
                    gmii_txd   <= 8'h00;
                    if (up.s_valid) begin
                        // First preamble byte is launched from IDLE itself.
                        gmii_tx_dv <= 1'b1;
                        gmii_txd   <= ETH_PREAMBLE;
                        cnt        <= cnt_t'(1);
                        state      <= (PRE_CNT > cnt_t'(1)) ? ST_PRE : ST_SFD;
                    end
                end
                ST_PRE: begin
                    gmii_txd <= ETH_PREAMBLE;
                    cnt      <= cnt_inc;
                    if (cnt_inc == PRE_CNT) state <= ST_SFD;
                end
                ST_SFD: begin
                    gmii_txd <= ETH_SFD;
                    crc      <= CRC32_INIT;
                    cnt      <= '0;
                    state    <= ST_DATA;
                end
                ST_DATA: begin
                    if (up.s_valid) begin
                        gmii_txd <= up.s_data;
                        crc      <= crc_next;
                        cnt      <= cnt_inc;
                        if (up.s_last) begin
                            if (cnt_inc < MIN_CNT) begin
                                state <= ST_PAD;
                            end else begin
                                cnt   <= '0;
                                state <= ST_FCS;
                            end
                        end
                    end else begin
                        // GMII cannot stall: abort the frame without an FCS.
                        gmii_tx_dv <= 1'b0;
                        gmii_txd   <= 8'h00;
                        underrun   <= 1'b1;
                        state      <= ST_DROP;
                    end
                end
                ST_PAD: begin
                    gmii_txd <= 8'h00;
                    crc      <= crc_next;
                    cnt      <= cnt_inc;
                    if (cnt_inc >= MIN_CNT) begin
                        cnt   <= '0;
                        state <= ST_FCS;
                    end
                end
                ST_FCS: begin
                    gmii_txd <= fcs_byte;
                    cnt      <= cnt_inc;
                    if (cnt[1:0] == 2'd3) begin
                        cnt   <= '0;
                        state <= ST_IFG;
                    end
                end
                ST_IFG: begin
                    gmii_tx_dv <= 1'b0;
                    gmii_txd   <= 8'h00;
                    // tx_dv still high on entry only when the last FCS byte is
                    // on the wire, which excludes the aborted-frame path.
                    tx_done    <= (cnt == '0) && gmii_tx_dv;
                    cnt        <= cnt_inc;
                    if (cnt_inc >= IFG_CNT) begin
                        cnt   <= '0;
                        state <= ST_IDLE;
                    end
                end
                ST_DROP: begin
                    gmii_tx_dv <= 1'b0;
                    gmii_txd   <= 8'h00;
                    if (up.s_valid && up.s_last) begin
                        cnt   <= '0;
                        state <= ST_IFG;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gmii_tx_framer.sv
module tb_gmii_tx_framer;
    import eth_pkg::*;

    typedef logic [7:0] bq_t[$];

    logic       clk     = 1'b0;
    logic       rst     = 1'b1;
    logic [7:0] d_data  = 8'h00;
    logic       d_valid = 1'b0;
    logic       d_last  = 1'b0;
    logic       use0    = 1'b0;   // 1: observe/drive the MIN_FRAME=0 instance

    int vectors     = 0;
    int miscompares = 0;

    always #4 clk = ~clk;

    gmii_tx_framer_if bus0 ();
    gmii_tx_framer_if bus1 ();

    assign bus0.s_data  = d_data;
    assign bus0.s_valid = d_valid & use0;
    assign bus0.s_last  = d_last;
    assign bus1.s_data  = d_data;
    assign bus1.s_valid = d_valid & ~use0;
    assign bus1.s_last  = d_last;

    logic       dv0, dv1, busy0, busy1, done0, done1, und0, und1;
    logic [7:0] txd0, txd1;

    gmii_tx_framer #(.MIN_FRAME(0)) dut0 (
        .gmii_tx_clk (clk),   .rst (rst),       .up (bus0.slave),
        .gmii_tx_dv  (dv0),   .gmii_txd (txd0), .tx_busy (busy0),
        .tx_done     (done0), .underrun (und0)
    );

    gmii_tx_framer dut (
        .gmii_tx_clk (clk),   .rst (rst),       .up (bus1.slave),
        .gmii_tx_dv  (dv1),   .gmii_txd (txd1), .tx_busy (busy1),
        .tx_done     (done1), .underrun (und1)
    );

    logic       m_dv, m_busy, m_done, m_und, m_ready;
    logic [7:0] m_txd;
    assign m_dv    = use0 ? dv0 : dv1;
    assign m_txd   = use0 ? txd0 : txd1;
    assign m_busy  = use0 ? busy0 : busy1;
    assign m_done  = use0 ? done0 : done1;
    assign m_und   = use0 ? und0 : und1;
    assign m_ready = use0 ? bus0.s_ready : bus1.s_ready;

    // Output monitor, sampled on the falling edge.
    logic [7:0] cap_q[$];
    bit         rdy_q[$];
    int         gap_q[$];
    int         done_cnt, und_cnt, und_bad, idle_rdy_cnt, gap_run;
    bit         prev_dv, seen;

    always @(negedge clk) begin
        if (m_dv) begin
            if (!prev_dv && seen) gap_q.push_back(gap_run);
            cap_q.push_back(m_txd);
            rdy_q.push_back(m_ready);
            gap_run = 0;
            seen    = 1'b1;
        end else begin
            gap_run++;
            if (m_ready) idle_rdy_cnt++;
        end
        if (m_done) done_cnt++;
        if (m_und) begin
            und_cnt++;
            if (m_dv || !prev_dv) und_bad++;
        end
        prev_dv = m_dv;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    // Non-reflected bit-serial CRC-32 with bit-reversed input; returns the FCS.
    function automatic logic [31:0] ref_fcs(input bq_t d);
        logic [31:0] c = 32'hFFFF_FFFF;
        logic [31:0] r;
        logic        fb;
        foreach (d[i]) begin
            for (int k = 0; k < 8; k++) begin
                fb = c[31] ^ d[i][k];
                c  = {c[30:0], 1'b0};
                if (fb) c = c ^ 32'h04C1_1DB7;
            end
        end
        for (int k = 0; k < 32; k++) r[k] = c[31-k];
        return ~r;
    endfunction

    function automatic bq_t build_exp(input bq_t d, input int min_len);
        bq_t         e;
        bq_t         body;
        logic [31:0] f;
        body = d;
        while (body.size() < min_len) body.push_back(8'h00);
        for (int i = 0; i < 7; i++) e.push_back(8'h55);
        e.push_back(8'hD5);
        foreach (body[i]) e.push_back(body[i]);
        f = ref_fcs(body);
        for (int k = 0; k < 4; k++) e.push_back(f[8*k +: 8]);
        return e;
    endfunction

    function automatic int count_diff(input bq_t a, input bq_t b, input int n);
        int d = 0;
        for (int i = 0; i < n; i++) begin
            if (i >= a.size() || i >= b.size()) d++;
            else if (a[i] !== b[i]) d++;
        end
        return d;
    endfunction

    function automatic bq_t make_data(input int n, input logic [7:0] seed);
        bq_t d;
        for (int i = 0; i < n; i++) d.push_back(seed + 8'(i * 7));
        return d;
    endfunction

    task automatic clear_mon();
        @(posedge clk);
        cap_q.delete(); rdy_q.delete(); gap_q.delete();
        done_cnt = 0; und_cnt = 0; und_bad = 0; idle_rdy_cnt = 0;
        gap_run = 0; seen = 1'b0;
    endtask

    // Presents bytes with valid; drop_at >= 0 withholds valid for one cycle there.
    task automatic send_frame(input bq_t data, input int drop_at, output bit ok);
        int i = 0;
        int guard = 0;
        bit dropped = 1'b0;
        bit acc;
        while (i < data.size() && guard < 4000) begin
            @(negedge clk);
            if (i == drop_at && !dropped) begin
                d_valid = 1'b0;
                dropped = 1'b1;
            end else begin
                d_valid = 1'b1;
                d_data  = data[i];
                d_last  = (i == data.size() - 1);
            end
            acc = d_valid && m_ready;
            @(posedge clk);
            if (acc) i++;
            guard++;
        end
        ok = (i == data.size());
    endtask

    task automatic end_frame();
        @(negedge clk);
        d_valid = 1'b0;
        d_last  = 1'b0;
    endtask

    task automatic wait_done(input int n, input string name);
        int t = 0;
        while (done_cnt < n && t < 4000) begin
            @(posedge clk);
            #1;
            t++;
        end
        vectors++;
        if (done_cnt < n) begin
            miscompares++;
            $display("FAIL %s_done_timeout: tx_done count %0d, required %0d", name, done_cnt, n);
        end
    endtask

    task automatic wait_idle(input string name);
        int t = 0;
        while ((busy0 || busy1) && t < 200) begin
            @(posedge clk);
            #1;
            t++;
        end
        vectors++;
        if (busy0 || busy1) begin
            miscompares++;
            $display("FAIL %s_idle_timeout: tx_busy %b/%b, required 0/0", name, busy0, busy1);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        vectors += 7;
        if (dv1 !== 1'b0)         begin miscompares++; $display("FAIL reset_dv: got %b, required 0", dv1); end
        if (txd1 !== 8'h00)       begin miscompares++; $display("FAIL reset_txd: got %h, required 00", txd1); end
        if (bus1.s_ready !== 1'b0) begin miscompares++; $display("FAIL reset_ready: got %b, required 0", bus1.s_ready); end
        if (busy1 !== 1'b0)       begin miscompares++; $display("FAIL reset_busy: got %b, required 0", busy1); end
        if (done1 !== 1'b0)       begin miscompares++; $display("FAIL reset_done: got %b, required 0", done1); end
        if (und1 !== 1'b0)        begin miscompares++; $display("FAIL reset_underrun: got %b, required 0", und1); end
        if (dv0 !== 1'b0)         begin miscompares++; $display("FAIL reset_dv0: got %b, required 0", dv0); end
        rst = 1'b0;
    endtask

    task automatic test_crc_check_value();
        logic [7:0] exp1 [21];
        bq_t d;
        bit  ok;
        exp1 = '{8'h55, 8'h55, 8'h55, 8'h55, 8'h55, 8'h55, 8'h55, 8'hD5,
                 8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39,
                 8'h26, 8'h39, 8'hF4, 8'hCB};
        use0 = 1'b1;
        clear_mon();
        for (int i = 0; i < 9; i++) d.push_back(8'h31 + 8'(i));
        send_frame(d, -1, ok);
        end_frame();
        wait_done(1, "crc9");
        wait_idle("crc9");
        vectors += 3;
        if (!ok) begin miscompares++; $display("FAIL crc9_accept: got %b, required 1", ok); end
        if (cap_q.size() !== 21) begin miscompares++; $display("FAIL crc9_dv_len: got %0d, required 21", cap_q.size()); end
        if (done_cnt !== 1) begin miscompares++; $display("FAIL crc9_done: got %0d, required 1", done_cnt); end
        for (int i = 0; i < 21; i++) begin
            vectors++;
            if (i >= cap_q.size() || cap_q[i] !== exp1[i]) begin
                miscompares++;
                $display("FAIL crc9_byte%0d: got %h, required %h", i,
                         (i < cap_q.size()) ? cap_q[i] : 8'hxx, exp1[i]);
            end
        end
        use0 = 1'b0;
    endtask

    task automatic test_padding();
        bq_t         d, e, body;
        bit          ok;
        logic [31:0] got_fcs, req_fcs;
        clear_mon();
        d = make_data(14, 8'h01);
        e = build_exp(d, 60);
        body = d;
        while (body.size() < 60) body.push_back(8'h00);
        req_fcs = ref_fcs(body);
        send_frame(d, -1, ok);
        end_frame();
        wait_done(1, "pad");
        wait_idle("pad");
        got_fcs = (cap_q.size() >= 72) ? {cap_q[71], cap_q[70], cap_q[69], cap_q[68]} : 32'hx;
        vectors += 4;
        if (cap_q.size() !== 72) begin miscompares++; $display("FAIL pad_dv_len: got %0d, required 72", cap_q.size()); end
        if (count_diff(cap_q, e, 68) !== 0) begin
            miscompares++; $display("FAIL pad_body: %0d differing bytes, required 0", count_diff(cap_q, e, 68));
        end
        if (got_fcs !== req_fcs) begin miscompares++; $display("FAIL pad_fcs: got %h, required %h", got_fcs, req_fcs); end
        if (done_cnt !== 1) begin miscompares++; $display("FAIL pad_done: got %0d, required 1", done_cnt); end
    endtask

    task automatic test_back_to_back();
        bq_t a, b, e;
        bit  ok_a, ok_b;
        int  bad = 0;
        clear_mon();
        a = make_data(64, 8'h10);
        b = make_data(64, 8'hA0);
        e = build_exp(a, 60);
        e = {e, build_exp(b, 60)};
        send_frame(a, -1, ok_a);
        send_frame(b, -1, ok_b);
        end_frame();
        wait_done(2, "b2b");
        wait_idle("b2b");
        if (rdy_q.size() < 152) bad = 999;
        else begin
            for (int f = 0; f < 2; f++) begin
                for (int p = 0; p < 7; p++) if (rdy_q[76*f + p] !== 1'b0) bad++;
                if (rdy_q[76*f + 7] !== 1'b1) bad++;
                for (int p = 72; p < 76; p++) if (rdy_q[76*f + p] !== 1'b0) bad++;
            end
        end
        vectors += 6;
        if (!(ok_a && ok_b)) begin miscompares++; $display("FAIL b2b_accept: got %b%b, required 11", ok_a, ok_b); end
        if (cap_q.size() !== 152) begin miscompares++; $display("FAIL b2b_dv_len: got %0d, required 152", cap_q.size()); end
        if (gap_q.size() < 1 || gap_q[0] !== 12) begin
            miscompares++; $display("FAIL b2b_gap: got %0d, required 12", (gap_q.size() > 0) ? gap_q[0] : -1);
        end
        if (count_diff(cap_q, e, 152) !== 0) begin
            miscompares++; $display("FAIL b2b_data: %0d differing bytes, required 0", count_diff(cap_q, e, 152));
        end
        if (bad !== 0) begin miscompares++; $display("FAIL b2b_ready_phase: %0d bad s_ready samples, required 0", bad); end
        if (idle_rdy_cnt !== 0) begin miscompares++; $display("FAIL b2b_ready_idle: got %0d, required 0", idle_rdy_cnt); end
    endtask

    task automatic test_underrun();
        bq_t d, e;
        bit  ok;
        int  n = 0;
        clear_mon();
        d = make_data(40, 8'h55);
        e = build_exp(d, 60);
        send_frame(d, 20, ok);
        while (n < 100) begin
            @(negedge clk);
            d_valid = 1'b0;
            d_last  = 1'b0;
            if (!m_busy) break;
            n++;
        end
        vectors += 7;
        if (!ok) begin miscompares++; $display("FAIL und_consumed: got %b, required 1", ok); end
        if (und_cnt !== 1) begin miscompares++; $display("FAIL und_pulse: got %0d, required 1", und_cnt); end
        if (und_bad !== 0) begin miscompares++; $display("FAIL und_dv_drop: got %0d misaligned pulses, required 0", und_bad); end
        if (cap_q.size() !== 28) begin miscompares++; $display("FAIL und_dv_len: got %0d, required 28", cap_q.size()); end
        if (count_diff(cap_q, e, 28) !== 0) begin
            miscompares++; $display("FAIL und_data: %0d differing bytes, required 0", count_diff(cap_q, e, 28));
        end
        if (n !== 12) begin miscompares++; $display("FAIL und_ifg_len: got %0d, required 12", n); end
        if (done_cnt !== 0) begin miscompares++; $display("FAIL und_no_done: got %0d, required 0", done_cnt); end
    endtask

    task automatic test_reset_mid_fcs();
        bq_t d, e;
        bit  ok;
        int  t = 0;
        clear_mon();
        d = make_data(20, 8'h40);
        e = build_exp(d, 60);
        send_frame(d, -1, ok);
        end_frame();
        while (cap_q.size() != 70 && t < 500) begin
            @(posedge clk);
            #1;
            t++;
        end
        vectors += 2;
        if (cap_q.size() !== 70) begin miscompares++; $display("FAIL rstfcs_reach: got %0d bytes, required 70", cap_q.size()); end
        if (m_txd !== e[70]) begin miscompares++; $display("FAIL rstfcs_byte2: got %h, required %h", m_txd, e[70]); end
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        vectors += 2;
        if (m_dv !== 1'b0) begin miscompares++; $display("FAIL rstfcs_dv: got %b, required 0", m_dv); end
        if (m_busy !== 1'b0) begin miscompares++; $display("FAIL rstfcs_busy: got %b, required 0", m_busy); end
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (20) @(posedge clk);
        vectors++;
        if (done_cnt !== 0) begin miscompares++; $display("FAIL rstfcs_no_done: got %0d, required 0", done_cnt); end

        clear_mon();
        d = make_data(61, 8'hC3);
        e = build_exp(d, 60);
        send_frame(d, -1, ok);
        end_frame();
        wait_done(1, "rstfcs_next");
        wait_idle("rstfcs_next");
        vectors += 2;
        if (cap_q.size() !== 73) begin miscompares++; $display("FAIL rstfcs_next_len: got %0d, required 73", cap_q.size()); end
        if (count_diff(cap_q, e, 73) !== 0) begin
            miscompares++; $display("FAIL rstfcs_next_data: %0d differing bytes, required 0", count_diff(cap_q, e, 73));
        end
    endtask

    task automatic test_long_frame();
        bq_t         d, e;
        bit          ok;
        logic [31:0] got_fcs, req_fcs;
        clear_mon();
        for (int i = 0; i < 1514; i++) d.push_back(8'($urandom_range(0, 255)));
        e = build_exp(d, 60);
        req_fcs = ref_fcs(d);
        send_frame(d, -1, ok);
        end_frame();
        wait_done(1, "long");
        wait_idle("long");
        got_fcs = (cap_q.size() >= 1526) ? {cap_q[1525], cap_q[1524], cap_q[1523], cap_q[1522]} : 32'hx;
        vectors += 4;
        if (!ok) begin miscompares++; $display("FAIL long_accept: got %b, required 1", ok); end
        if (cap_q.size() !== 1526) begin miscompares++; $display("FAIL long_dv_len: got %0d, required 1526", cap_q.size()); end
        if (count_diff(cap_q, e, 1522) !== 0) begin
            miscompares++; $display("FAIL long_data: %0d differing bytes, required 0", count_diff(cap_q, e, 1522));
        end
        if (got_fcs !== req_fcs) begin miscompares++; $display("FAIL long_fcs: got %h, required %h", got_fcs, req_fcs); end
    endtask

    initial begin
        test_reset();
        test_crc_check_value();
        test_padding();
        test_back_to_back();
        test_underrun();
        test_reset_mid_fcs();
        test_long_frame();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
